// File: rtl/int_source.sv
//------------------------------------------------------------------------------
// int_source : programmable external interrupt source with ack handshake,
//              periodic / PC-match triggering and event statistics.
// Revision   : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module int_source #(
  parameter logic [31:0] ACK_ADDR = 32'h0000_7F20,
  parameter int          HOLDOFF  = 4,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_mode,
  input  logic [31:0]      cfg_period,
  input  logic [31:0]      cfg_pc,
  input  logic [31:0]      macroscopic_pc,
  input  logic [31:0]      m_int_addr,
  input  logic [3:0]       m_int_byteen,
  output logic             interrupt,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] int_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] spurious_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_PENDING = 2'd2,
    S_HOLDOFF = 2'd3
  } state_e;

  localparam logic [31:0] C_HOLD_INIT = (HOLDOFF > 0) ? 32'(HOLDOFF - 1) : 32'd0;

  state_e           state_q, state_d;
  logic             int_q, int_d;
  logic [1:0]       mode_q, mode_d;
  logic [31:0]      period_q, period_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      timer_q, timer_d;
  logic [31:0]      hold_q, hold_d;
  logic             pc_match_dly_q, pc_match_dly_d;
  logic [CNT_W-1:0] int_cnt_q, int_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] spur_cnt_q, spur_cnt_d;

  logic        w_ack;
  logic [31:0] w_period_eff;
  logic        w_expire;
  logic        w_pc_match;
  logic        w_trigger;
  state_e      w_rearm;
  logic        w_unused_addr_bits;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Byte offset within the ack word is irrelevant.
  assign w_unused_addr_bits = ^m_int_addr[1:0];
  assign w_ack        = (m_int_addr[31:2] == ACK_ADDR[31:2]) && (m_int_byteen != 4'd0);
  assign w_period_eff = (period_q == 32'd0) ? 32'd1 : period_q;
  assign w_expire     = (timer_q == w_period_eff - 32'd1);
  assign w_pc_match   = (macroscopic_pc == pc_q);
  // Edge-detect the match so a stalled PC fires only once.
  assign w_trigger    = (mode_q == 2'd1) ? w_expire
                                         : (mode_q[1] && w_pc_match && !pc_match_dly_q);
  assign w_rearm      = (mode_q == 2'd2) ? S_IDLE : S_ARMED;

  always_comb begin
    state_d        = state_q;
    int_d          = int_q;
    mode_d         = mode_q;
    period_d       = period_q;
    pc_d           = pc_q;
    hold_d         = hold_q;
    int_cnt_d      = int_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    spur_cnt_d     = spur_cnt_q;
    pc_match_dly_d = w_pc_match;
    timer_d        = timer_q;
    if (state_q != S_IDLE) begin
      timer_d = w_expire ? 32'd0 : timer_q + 32'd1;
    end

    if (cfg_we) begin
      mode_d         = cfg_mode;
      period_d       = cfg_period;
      pc_d           = cfg_pc;
      timer_d        = 32'd0;
      pc_match_dly_d = 1'b0;
      int_d          = 1'b0;
      state_d        = (cfg_mode != 2'd0) ? S_ARMED : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_ack) spur_cnt_d = sat_inc(spur_cnt_q);
        end
        S_ARMED: begin
          if (w_ack) spur_cnt_d = sat_inc(spur_cnt_q);
          if (w_trigger) begin
            state_d   = S_PENDING;
            int_d     = 1'b1;
            int_cnt_d = sat_inc(int_cnt_q);
          end
        end
        S_PENDING: begin
          if (w_trigger) miss_cnt_d = sat_inc(miss_cnt_q);
          if (w_ack) begin
            int_d = 1'b0;
            if (HOLDOFF > 0) begin
              state_d = S_HOLDOFF;
              hold_d  = C_HOLD_INIT;
            end else begin
              state_d = w_rearm;
            end
          end
        end
        default: begin
          if (w_trigger) miss_cnt_d = sat_inc(miss_cnt_q);
          if (w_ack)     spur_cnt_d = sat_inc(spur_cnt_q);
          if (hold_q == 32'd0) state_d = w_rearm;
          else                 hold_d  = hold_q - 32'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      int_q          <= 1'b0;
      mode_q         <= 2'd0;
      period_q       <= 32'd0;
      pc_q           <= 32'd0;
      timer_q        <= 32'd0;
      hold_q         <= 32'd0;
      pc_match_dly_q <= 1'b0;
      int_cnt_q      <= '0;
      miss_cnt_q     <= '0;
      spur_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      int_q          <= int_d;
      mode_q         <= mode_d;
      period_q       <= period_d;
      pc_q           <= pc_d;
      timer_q        <= timer_d;
      hold_q         <= hold_d;
      pc_match_dly_q <= pc_match_dly_d;
      int_cnt_q      <= int_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
      spur_cnt_q     <= spur_cnt_d;
    end
  end

  assign interrupt      = int_q;
  assign state          = state_q;
  assign int_count      = int_cnt_q;
  assign miss_count     = miss_cnt_q;
  assign spurious_count = spur_cnt_q;

endmodule

`default_nettype wire

// File: doc/int_source.md
Name: int_source

Overview:
- Programmable external interrupt source. It is the responder for the CPU's interrupt-acknowledge path.
- It drives the `interrupt` input of the mips top, which maps to HWInt[2].
- It holds that level until the CPU acknowledges by writing to the interrupt-ack address on m_int_addr/m_int_byteen.
- It triggers periodically, or on a macroscopic-PC match. It keeps counters for raised, missed and spurious-ack events for the testbench.

Parameters:
- ACK_ADDR, 32'h0000_7F20, word address of the interrupt-acknowledge location; compared on bits [31:2].
- HOLDOFF, 4, cycles the interrupt is held low after an ack before re-arming; 0 means re-arm immediately.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cfg_we  input  1  load configuration this cycle
- cfg_mode  input  2  0 off, 1 periodic, 2 PC-match one-shot, 3 PC-match repeat
- cfg_period  input  32  periodic interval in cycles
- cfg_pc  input  32  target macroscopic PC
- macroscopic_pc  input  32  CPU macroscopic PC
- m_int_addr  input  32  CPU interrupt-ack address
- m_int_byteen  input  4  CPU interrupt-ack byte enables
- interrupt  output  1  interrupt level to the CPU
- state  output  2  0 IDLE, 1 ARMED, 2 PENDING, 3 HOLDOFF
- int_count  output  CNT_W  interrupts raised
- miss_count  output  CNT_W  triggers dropped while PENDING/HOLDOFF
- spurious_count  output  CNT_W  acks received outside PENDING

Behaviour:
- Reset (synchronous, active-high): interrupt=0, state=IDLE, all counters, mode/period/pc registers, timer, holdoff counter and pc_match_d cleared to 0.
- Ack definition: ack = (m_int_addr[31:2]==ACK_ADDR[31:2]) && (m_int_byteen!=0). Bits [1:0] of the address are ignored.
- Trigger, periodic (mode 1):
  - Timer increments every cycle while not IDLE.
  - Expiry when timer == max(period,1)-1; timer then wraps to 0.
  - period 0 behaves as period 1, i.e. expiry every cycle.
- Trigger, PC match (modes 2/3):
  - pc_match = (macroscopic_pc==pc_reg); trigger = pc_match && !pc_match_d.
  - This rising-edge detection makes a stalled PC fire once.
  - pc_match_d updates every cycle, in all states.
- cfg_we has top priority:
  - Next cycle mode/period/pc registers take the inputs, timer=0, pc_match_d=0, interrupt=0.
  - state=ARMED if cfg_mode!=0, else IDLE.
  - Any ack or trigger in that same cycle is ignored; no counter changes.
- State transitions (all registered; outputs change on the edge after the condition):
  - IDLE: interrupt 0; triggers ignored. An ack increments spurious_count.
  - ARMED: on trigger, go to PENDING, interrupt=1, int_count+1. An ack increments spurious_count; a simultaneous trigger still fires.
  - PENDING: interrupt held 1 indefinitely.
    - On ack: interrupt=0. If HOLDOFF>0, go to HOLDOFF with holdoff counter=HOLDOFF-1. If HOLDOFF=0, go to the re-arm target directly.
    - A trigger in PENDING increments miss_count, including in the same cycle as the ack.
  - HOLDOFF: interrupt 0; holdoff counter decrements each cycle. At 0, go to the re-arm target.
    - Triggers increment miss_count.
    - An ack increments spurious_count.
  - Re-arm target: ARMED for modes 1 and 3; IDLE for mode 2.
- Counters saturate at all-ones; there is no wrap.
- Timer keeps running through PENDING and HOLDOFF, so periodic spacing is not stretched by ack latency.
- interrupt is a direct register output, with no combinational path from the inputs.

Test Plan:
- Reset, then cfg_we with mode=1, period=5 -> state ARMED the cycle after; interrupt rises 5 cycles after config; int_count=1; interrupt stays high for 20 cycles with no ack.
- Interrupt pending, then a one-cycle ack (addr=0x7F20, byteen=4'b0001) -> interrupt 0 next cycle; state HOLDOFF for 4 cycles, then ARMED. With addr=0x7F23 the ack is also accepted; with byteen=0 it is not.
- mode=1, period=2, never ack -> int_count=1; miss_count increments every 2 cycles; saturation checked with CNT_W=4 (stops at 15).
- mode=2, pc=0x3008, macroscopic_pc held at 0x3008 for 3 cycles -> a single interrupt; after ack and holdoff, state IDLE. A later re-match does not fire.
- mode=3, PC toggles 0x3008/0x300c, ack each time -> one interrupt per rising match outside PENDING/HOLDOFF; matches during holdoff appear in miss_count.
- Ack while IDLE -> spurious_count=1. cfg_we with mode=0 while PENDING -> interrupt 0 and state IDLE next cycle; a simultaneous ack leaves spurious_count unchanged. Reset mid-PENDING -> all outputs 0 next cycle.
